// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mac_pkg
// Brief    : Shared types and constants for the dot-product MAC slice.
// Revision : 1.0 - initial release
// ============================================================================
package mac_pkg;

  // Control states: gathering products, or holding a finished result
  typedef enum logic [0:0] {
    S_ACC = 1'b0,
    S_OUT = 1'b1
  } state_t;

  // Smallest accumulator that cannot overflow for LEN full-scale products
  function automatic int acc_width(input int width, input int len);
    return 2 * width + $clog2(len);
  endfunction

  localparam int c_def_width     = 8;
  localparam int c_def_len       = 4;
  localparam int c_def_acc_width = acc_width(c_def_width, c_def_len);

endpackage
`default_nettype wire

// File: rtl/dot_product_mac_if.sv
`default_nettype none
// ============================================================================
// Module   : dot_product_mac_if
// Brief    : Operand-in / result-out handshake bundle for dot_product_mac.
// Revision : 1.0 - initial release
// ============================================================================
interface dot_product_mac_if #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 18
);

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_data;

  // Producer/consumer side
  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data
  );

  // MAC side
  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface
`default_nettype wire

// File: rtl/multiplier.sv
`default_nettype none
// ============================================================================
// Module   : multiplier
// Brief    : Combinational unsigned WIDTH x WIDTH array multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module multiplier #(
  parameter int WIDTH = 8
) (
  input  wire logic [WIDTH-1:0]   i_a,
  input  wire logic [WIDTH-1:0]   i_b,
  output logic      [2*WIDTH-1:0] o_prod
);

  localparam int c_pw = 2 * WIDTH;

  // Full-width product; operands widened so no high bits are lost
  assign o_prod = c_pw'(i_a) * c_pw'(i_b);

endmodule
`default_nettype wire

// File: rtl/dot_product_mac.sv
`default_nettype none
// ============================================================================
// Module   : dot_product_mac
// Brief    : Streaming unsigned MAC; sums LEN operand-pair products and
//            presents each sum on a held valid/ready result port.
// Revision : 1.0 - initial release
// ============================================================================
module dot_product_mac
  import mac_pkg::*;
#(
  parameter int WIDTH     = c_def_width,
  parameter int LEN       = c_def_len,
  parameter int ACC_WIDTH = acc_width(WIDTH, LEN)
) (
  input  wire logic         clk,
  input  wire logic         rst,
  dot_product_mac_if.slave  bus
);

  localparam int                 c_cnt_w = $clog2(LEN + 1);
  localparam logic [c_cnt_w-1:0] c_len   = c_cnt_w'(LEN);

  state_t                 r_state;
  logic [c_cnt_w-1:0]     r_cnt;
  logic [ACC_WIDTH-1:0]   r_acc;
  logic [ACC_WIDTH-1:0]   r_out_data;
  logic                   r_out_valid;
  logic [WIDTH-1:0]       r_op_a;
  logic [WIDTH-1:0]       r_op_b;
  logic                   r_op_valid;

  logic                   w_in_ready;
  logic                   w_accept;
  logic                   w_out_fire;
  logic [2*WIDTH-1:0]     w_prod;
  logic [ACC_WIDTH-1:0]   w_prod_ext;
  logic [ACC_WIDTH-1:0]   w_sum;

  // Input is open only while gathering and the batch is not yet full
  assign w_in_ready = (r_state == S_ACC) && (r_cnt < c_len);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_out_fire = r_out_valid && bus.out_ready;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;

  multiplier #(
    .WIDTH (WIDTH)
  ) u_multiplier (
    .i_a    (r_op_a),
    .i_b    (r_op_b),
    .o_prod (w_prod)
  );

  // Zero-extended product; the running sum wraps silently at ACC_WIDTH
  assign w_prod_ext = ACC_WIDTH'(w_prod);
  assign w_sum      = r_acc + w_prod_ext;

  // Operand stage: capture accepted pair, valid for exactly one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_op_valid <= 1'b0;
    end else begin
      r_op_valid <= w_accept;
      if (w_accept) begin
        r_op_a <= bus.in_a;
        r_op_b <= bus.in_b;
      end
    end
  end

  // Pair counter: counts accepts, cleared when the result is taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + c_cnt_w'(1);
    end else if (w_out_fire) begin
      r_cnt <= '0;
    end
  end

  // Control FSM with accumulator and registered result port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_ACC;
      r_acc       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_ACC: begin
          if (r_op_valid) begin
            if (r_cnt == c_len) begin
              // Last product folds straight into the result register
              r_out_data  <= w_sum;
              r_out_valid <= 1'b1;
              r_acc       <= '0;
              r_state     <= S_OUT;
            end else begin
              r_acc <= w_sum;
            end
          end
        end
        S_OUT: begin
          if (w_out_fire) begin
            r_out_valid <= 1'b0;
            r_state     <= S_ACC;
          end
        end
        default: begin
          r_state <= S_ACC;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dot_product_mac.sv
`default_nettype none
// ============================================================================
// Module   : tb_dot_product_mac
// Brief    : Self-checking bench for dot_product_mac (LEN=4 and LEN=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dot_product_mac;

  localparam int    WIDTH     = 8;
  localparam int    LEN       = 4;
  localparam int    ACC_WIDTH = 18;
  localparam longint c_mask   = (64'd1 << ACC_WIDTH) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  dot_product_mac_if #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) bus0 ();
  dot_product_mac_if #(.WIDTH(WIDTH), .ACC_WIDTH(16))        bus1 ();

  dot_product_mac #(.WIDTH(WIDTH), .LEN(LEN), .ACC_WIDTH(ACC_WIDTH)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  dot_product_mac #(.WIDTH(WIDTH), .LEN(1), .ACC_WIDTH(16)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  // Transaction-level model: products are summed as pairs are accepted,
  // the batch total appears one cycle after the LEN-th accept and is held
  // until taken.
  int     m_cnt;
  longint m_sum;
  longint m_out_data;
  bit     m_out_valid;

  int     n_pass = 0;
  int     n_total = 0;
  longint last_out;
  int     ov_cycles;
  int     rdy_low;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic model_reset();
    m_cnt       = 0;
    m_sum       = 0;
    m_out_data  = 0;
    m_out_valid = 0;
  endtask

  function automatic bit model_ready();
    return (m_cnt < LEN) && !m_out_valid;
  endfunction

  // One clock: advance the model on the edge, compare on the falling edge
  task automatic step();
    bit acc, hs, pend;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      acc  = bus0.in_valid && model_ready();
      hs   = m_out_valid && bus0.out_ready;
      pend = (m_cnt == LEN) && !m_out_valid;
      if (hs) begin
        m_out_valid = 0;
        m_cnt       = 0;
      end
      if (pend) begin
        m_out_valid = 1;
        m_out_data  = m_sum;
        m_sum       = 0;
      end
      if (acc) begin
        m_sum = (m_sum + longint'(bus0.in_a) * longint'(bus0.in_b)) & c_mask;
        m_cnt++;
      end
    end
    @(negedge clk);
    chk("in_ready",  longint'(bus0.in_ready),  longint'(model_ready()));
    chk("out_valid", longint'(bus0.out_valid), longint'(m_out_valid));
    chk("out_data",  longint'(bus0.out_data),  m_out_data);
    if (!bus0.in_ready) rdy_low++;
    if (bus0.out_valid) begin
      ov_cycles++;
      last_out = longint'(bus0.out_data);
    end
  endtask

  task automatic drive(input bit v, input int a, input int b, input bit r);
    bus0.in_valid  = v;
    bus0.in_a      = WIDTH'(a);
    bus0.in_b      = WIDTH'(b);
    bus0.out_ready = r;
  endtask

  task automatic clear_stats();
    last_out  = -1;
    ov_cycles = 0;
    rdy_low   = 0;
  endtask

  // Four equal pairs then idle cycles with consumer ready
  task automatic batch_same(input int a, input int b);
    for (int i = 0; i < 4; i++) begin
      drive(1, a, b, 1);
      step();
    end
    drive(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step();
  endtask

  initial begin
    drive(0, 0, 0, 1);
    bus1.in_valid  = 1'b0;
    bus1.in_a      = '0;
    bus1.in_b      = '0;
    bus1.out_ready = 1'b1;
    model_reset();
    clear_stats();

    // Reset state
    step();
    step();
    chk("rst_in_ready",  longint'(bus0.in_ready), 1);
    chk("rst_out_valid", longint'(bus0.out_valid), 0);
    rst = 1'b0;
    step();

    // Back-to-back (1,2),(3,4),(5,6),(7,8)
    clear_stats();
    for (int i = 0; i < 4; i++) begin
      drive(1, 2 * i + 1, 2 * i + 2, 1);
      step();
    end
    drive(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step();
    chk("b2b_sum",       last_out, 100);
    chk("b2b_model_sum", m_out_data, 100);
    chk("b2b_ov_cycles", ov_cycles, 1);
    chk("b2b_rdy_low",   rdy_low, 2);

    // Full-scale operands, two batches
    clear_stats();
    batch_same(255, 255);
    chk("max_sum_1", last_out, 260100);
    clear_stats();
    batch_same(255, 255);
    chk("max_sum_2", last_out, 260100);

    // Bubbles with junk operands on idle cycles
    begin
      int vpat[7] = '{1, 0, 0, 1, 0, 1, 1};
      int k = 0;
      clear_stats();
      for (int i = 0; i < 7; i++) begin
        if (vpat[i] != 0) begin
          drive(1, 2 * k + 1, 2 * k + 2, 1);
          k++;
        end else begin
          drive(0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1);
        end
        step();
      end
      drive(0, 0, 0, 1);
      for (int i = 0; i < 3; i++) step();
      chk("bubble_sum", last_out, 100);
    end

    // Consumer stall while (9,9) is offered
    clear_stats();
    for (int i = 0; i < 4; i++) begin
      drive(1, 2 * i + 1, 2 * i + 2, 0);
      step();
    end
    drive(0, 0, 0, 0);
    step();
    for (int i = 0; i < 5; i++) begin
      drive(1, 9, 9, 0);
      step();
      chk("hold_data",     longint'(bus0.out_data), 100);
      chk("hold_valid",    longint'(bus0.out_valid), 1);
      chk("hold_in_ready", longint'(bus0.in_ready), 0);
    end
    drive(0, 0, 0, 1);
    step();
    step();
    clear_stats();
    batch_same(1, 1);
    chk("after_hold_sum", last_out, 4);

    // Asynchronous reset after two accepts
    for (int i = 0; i < 2; i++) begin
      drive(1, 3, 3, 1);
      step();
    end
    drive(0, 0, 0, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", longint'(bus0.out_valid), 0);
    chk("async_rst_out_data",  longint'(bus0.out_data), 0);
    chk("async_rst_in_ready",  longint'(bus0.in_ready), 1);
    model_reset();
    step();
    rst = 1'b0;
    clear_stats();
    batch_same(2, 2);
    chk("post_rst_sum", last_out, 16);

    // Randomized traffic against the model
    clear_stats();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)), $urandom_range(0, 2) != 0);
      step();
    end
    drive(0, 0, 0, 1);
    for (int i = 0; i < 8; i++) step();
    chk("rand_results_seen", longint'(ov_cycles > 0), 1);

    // LEN=1 instance: result one cycle after the single accept
    bus1.in_valid = 1'b1;
    bus1.in_a     = 8'd10;
    bus1.in_b     = 8'd20;
    step();
    bus1.in_valid = 1'b0;
    chk("len1_valid_at_accept", longint'(bus1.out_valid), 0);
    chk("len1_in_ready_full",   longint'(bus1.in_ready), 0);
    step();
    chk("len1_valid", longint'(bus1.out_valid), 1);
    chk("len1_data",  longint'(bus1.out_data), 200);
    step();
    chk("len1_valid_cleared", longint'(bus1.out_valid), 0);
    chk("len1_in_ready_back", longint'(bus1.in_ready), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
